// File: rtl/dsp_out_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : dsp_out_pkg
//  Purpose  : Shared widths, the stage-1 payload type and the
//             round/shift/saturate function used by the accumulator
//             output stage.
//  Contents : ACC_IN_W, ACC_OUT_W   default accumulator/output widths
//             s1_payload_t          {data, sat} produced by stage 1
//             round_shift_sat()     round-half-up shift plus saturation
//  Revision : 1.0  initial release
// ============================================================================
package dsp_out_pkg;

   localparam int ACC_IN_W  = 38;
   localparam int ACC_OUT_W = 20;

   // Working width of the function. Callers zero-extend their operand to
   // this width and keep the low OUT_W bits of the result, so one function
   // serves every legal IN_W/OUT_W pair (IN_W < c_rs_w, OUT_W < c_rs_w).
   localparam int c_rs_w = 64;

   localparam logic [c_rs_w:0] c_rs_one = 1;

   typedef struct packed {
      logic [c_rs_w-1:0] data;
      logic              sat;
   } s1_payload_t;

   // t = (z + r) >> s with r = 2^(s-1) (0 for s = 0), evaluated one bit wider
   // than the operand so the rounding carry survives. Shifts beyond the
   // operand width give 0; s = in_w naturally reduces to z[in_w-1].
   function automatic s1_payload_t round_shift_sat(
      input logic [c_rs_w-1:0] z,
      input logic [5:0]        s,
      input int unsigned       in_w,
      input int unsigned       out_w
   );
      logic [c_rs_w:0] r;
      logic [c_rs_w:0] sum;
      logic [c_rs_w:0] t;
      logic [c_rs_w:0] max_v;
      s1_payload_t     res;

      r     = (s == 6'd0) ? '0 : (c_rs_one << (s - 6'd1));
      sum   = {1'b0, z} + r;
      t     = (32'(s) >= (in_w + 32'd1)) ? '0 : (sum >> s);
      max_v = (c_rs_one << out_w) - c_rs_one;

      if (t > max_v) begin
         res.data = max_v[c_rs_w-1:0];
         res.sat  = 1'b1;
      end else begin
         res.data = t[c_rs_w-1:0];
         res.sat  = 1'b0;
      end
      return res;
   endfunction

endpackage
`default_nettype wire

// File: rtl/dsp_sync_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : dsp_sync_fifo
//  Purpose  : Single-clock FIFO with a registered head output. A push while
//             full is accepted only when a pop happens in the same cycle;
//             otherwise it is ignored (the caller reports the drop).
//  Ports    : clk, reset     clock, synchronous active-high reset
//             push, din      write request and data
//             pop            read request (ignored when empty)
//             dout           registered head entry, 0 when empty
//             full, empty    occupancy status
//  Revision : 1.0  initial release
// ============================================================================
module dsp_sync_fifo #(
   parameter int WIDTH = 20,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty
);

   localparam int                c_addr_w   = $clog2(DEPTH);
   localparam logic [c_addr_w:0] c_cnt_full = (c_addr_w + 1)'(DEPTH);
   localparam logic [c_addr_w-1:0] c_ptr_one = 1;

   logic [WIDTH-1:0]    r_mem [DEPTH];
   logic [c_addr_w-1:0] r_wr_ptr;
   logic [c_addr_w-1:0] r_rd_ptr;
   logic [c_addr_w:0]   r_count;
   logic [WIDTH-1:0]    r_dout;

   logic                w_pop;
   logic                w_wr_en;
   logic [c_addr_w-1:0] w_wr_ptr_nxt;
   logic [c_addr_w-1:0] w_rd_ptr_nxt;
   logic [c_addr_w:0]   w_count_nxt;
   logic [WIDTH-1:0]    w_head_nxt;

   assign full  = (r_count == c_cnt_full);
   assign empty = (r_count == '0);
   assign dout  = r_dout;

   assign w_pop   = pop & ~empty;
   // When full, the slot being freed by a simultaneous pop takes the new entry.
   assign w_wr_en = push & (~full | w_pop);

   assign w_wr_ptr_nxt = w_wr_en ? (r_wr_ptr + c_ptr_one) : r_wr_ptr;
   assign w_rd_ptr_nxt = w_pop   ? (r_rd_ptr + c_ptr_one) : r_rd_ptr;
   assign w_count_nxt  = r_count + {{c_addr_w{1'b0}}, w_wr_en}
                                 - {{c_addr_w{1'b0}}, w_pop};

   // The head is precomputed so dout comes straight from a register. If the
   // slot written this cycle becomes the head (FIFO was empty, or drained to
   // it), bypass the incoming data since r_mem is not yet updated.
   always_comb begin
      w_head_nxt = '0;
      if (w_count_nxt != '0) begin
         if (w_wr_en && (r_wr_ptr == w_rd_ptr_nxt)) begin
            w_head_nxt = din;
         end else begin
            w_head_nxt = r_mem[w_rd_ptr_nxt];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (w_wr_en) begin
         r_mem[r_wr_ptr] <= din;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         r_dout   <= '0;
      end else begin
         r_wr_ptr <= w_wr_ptr_nxt;
         r_rd_ptr <= w_rd_ptr_nxt;
         r_count  <= w_count_nxt;
         r_dout   <= w_head_nxt;
      end
   end

endmodule
`default_nettype wire

// File: rtl/dsp_accum_out_round_sat.sv
`default_nettype none
// ============================================================================
//  Module   : dsp_accum_out_round_sat
//  Purpose  : Post-processing for the DSP multiply-add accumulator output:
//             round-half-up right shift, saturation to OUT_W bits, then a
//             small FIFO towards a valid/ready consumer. Never stalls the
//             accumulator; overflow and drops raise sticky flags.
//  Ports    : clk, reset            clock, synchronous active-high reset
//             z_in, z_valid, shift  accumulator sample and shift amount
//             out_data, out_valid   FIFO head towards the consumer
//             out_ready             consumer accepts the head this cycle
//             sat_flag, drop_flag   sticky saturation / drop indications
//             clr_flags             clears both sticky flags
//  Revision : 1.0  initial release
// ============================================================================
module dsp_accum_out_round_sat
   import dsp_out_pkg::*;
#(
   parameter int IN_W  = ACC_IN_W,
   parameter int OUT_W = ACC_OUT_W,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [IN_W-1:0]  z_in,
   input  logic             z_valid,
   input  logic [5:0]       shift,
   output logic [OUT_W-1:0] out_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             sat_flag,
   output logic             drop_flag,
   input  logic             clr_flags
);

   logic [c_rs_w-1:0]       w_z_ext;
   s1_payload_t             w_rs;
   logic [c_rs_w-1:OUT_W]   w_unused_rs_hi;

   logic                    r_s1_valid;
   logic [OUT_W-1:0]        r_s1_data;
   logic                    r_s1_sat;

   logic                    w_full;
   logic                    w_empty;
   logic                    w_pop;
   logic                    w_drop;
   logic                    w_sat_set;

   logic                    r_sat_flag;
   logic                    r_drop_flag;

   // ---------------------------------------------------------------- stage 1
   assign w_z_ext = {{(c_rs_w - IN_W){1'b0}}, z_in};
   assign w_rs    = round_shift_sat(w_z_ext, shift, IN_W, OUT_W);

   // Saturation bounds the result to OUT_W bits, so the upper bits are zero.
   assign w_unused_rs_hi = w_rs.data[c_rs_w-1:OUT_W];

   always_ff @(posedge clk) begin
      if (reset) begin
         r_s1_valid <= 1'b0;
         r_s1_data  <= '0;
         r_s1_sat   <= 1'b0;
      end else begin
         r_s1_valid <= z_valid;
         r_s1_data  <= w_rs.data[OUT_W-1:0];
         r_s1_sat   <= w_rs.sat;
      end
   end

   // ---------------------------------------------------------------- stage 2
   dsp_sync_fifo #(
      .WIDTH (OUT_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (r_s1_valid),
      .pop   (w_pop),
      .din   (r_s1_data),
      .dout  (out_data),
      .full  (w_full),
      .empty (w_empty)
   );

   assign out_valid = ~w_empty;
   assign w_pop     = out_valid & out_ready;

   // ------------------------------------------------------------------ flags
   // A saturated sample counts even if the FIFO then discards it.
   assign w_sat_set = r_s1_valid & r_s1_sat;
   assign w_drop    = r_s1_valid & w_full & ~w_pop;

   // Set has priority over clear so an event coinciding with clr is kept.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_sat_flag  <= 1'b0;
         r_drop_flag <= 1'b0;
      end else begin
         if (w_sat_set) begin
            r_sat_flag <= 1'b1;
         end else if (clr_flags) begin
            r_sat_flag <= 1'b0;
         end
         if (w_drop) begin
            r_drop_flag <= 1'b1;
         end else if (clr_flags) begin
            r_drop_flag <= 1'b0;
         end
      end
   end

   assign sat_flag  = r_sat_flag;
   assign drop_flag = r_drop_flag;

endmodule
`default_nettype wire
